// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Branch history table of 2-bit saturating counters plus EX-stage
// misprediction resolver for the 5-stage pipeline.
//   - ID side: combinational prediction for lookup_pc_i.
//   - EX side: trains the table, raises flush_o on a mispredict and
//     supplies the corrected fetch PC.
// Optional build macro: BPRED_BYPASS_EN
//   When defined, a lookup that hits the entry being trained in the same
//   cycle sees the post-update counter instead of the stored one.
module branch_resolve_unit #(
  parameter int ENTRIES = 16,
  parameter int IDX_LSB = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lookup_pc_i,
  output logic        predTaken_o,
  input  logic        Branch_i,
  input  logic        predTaken_i,
  input  logic        zero_i,
  input  logic [31:0] pc_branch_i,
  input  logic [31:0] pc_default_i,
  output logic        flush_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  // Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST; prediction is the MSB.
  logic [1:0]       table_q [ENTRIES];
  logic [31:0]      branch_cnt_q;
  logic [31:0]      mispred_cnt_q;

  logic [31:0]      upd_pc;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [1:0]       cur_ctr;
  logic [1:0]       new_ctr;
  logic             update_en;
  logic             mispredict;
  logic             unused_bits;

  // The branch PC is recovered from its fall-through address; wraps at 0.
  assign upd_pc     = pc_default_i - 32'd4;
  assign lookup_idx = lookup_pc_i[IDX_LSB +: IDX_W];
  assign upd_idx    = upd_pc[IDX_LSB +: IDX_W];

  // Only part of each PC feeds the index; the rest is intentionally ignored.
  assign unused_bits = ^{lookup_pc_i, upd_pc};

  // Reset wins over a branch sitting in EX: nothing is trained or counted.
  assign update_en  = Branch_i & ~rst_i;
  assign mispredict = update_en & (predTaken_i != zero_i);

  assign flush_o       = mispredict;
  assign redirect_pc_o = zero_i ? pc_branch_i : pc_default_i;
  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

  // Saturating next value for the entry addressed by the resolving branch.
  always_comb begin
    cur_ctr = table_q[upd_idx];
    new_ctr = cur_ctr;
    if (zero_i) begin
      if (cur_ctr != 2'b11) new_ctr = cur_ctr + 2'b01;
    end else begin
      if (cur_ctr != 2'b00) new_ctr = cur_ctr - 2'b01;
    end
  end

  // ID-stage prediction read, optionally forwarding a same-cycle update.
  always_comb begin
    predTaken_o = table_q[lookup_idx][1];
`ifdef BPRED_BYPASS_EN
    if (update_en && (lookup_idx == upd_idx)) predTaken_o = new_ctr[1];
`else
`endif
  end

  // Table training and statistics; reset reinitialises everything to ST / 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= 2'b11;
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else if (Branch_i) begin
      table_q[upd_idx] <= new_ctr;
      branch_cnt_q     <= branch_cnt_q + 32'd1;
      if (mispredict) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit (ENTRIES=16, IDX_LSB=2).
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_o;
  logic        br;
  logic        pred_i;
  logic        zero;
  logic [31:0] pc_b;
  logic [31:0] pc_d;
  logic        flush;
  logic [31:0] redir;
  logic [31:0] bcnt;
  logic [31:0] mcnt;

  int n_tests = 0;
  int n_fail  = 0;

  branch_resolve_unit #(.ENTRIES(16), .IDX_LSB(2)) dut (
    .clk_i(clk), .rst_i(rst), .lookup_pc_i(lookup_pc), .predTaken_o(pred_o),
    .Branch_i(br), .predTaken_i(pred_i), .zero_i(zero),
    .pc_branch_i(pc_b), .pc_default_i(pc_d), .flush_o(flush),
    .redirect_pc_o(redir), .branch_cnt_o(bcnt), .mispred_cnt_o(mcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BPRED_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Directed vectors: one clock cycle each. pred/flush/redir checked before
  // the edge, counts checked after it.
  typedef struct {
    logic        rst;
    logic [31:0] lpc;
    logic        br;
    logic        pred;
    logic        zero;
    logic [31:0] pcb;
    logic [31:0] pcd;
    logic        e_pred;
    logic        e_flush;
    logic [31:0] e_redir;
    logic [31:0] e_bcnt;
    logic [31:0] e_mcnt;
  } vec_t;

  vec_t vecs [17];

  // Behavioural reference model.
  int          m_ctr [16];
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  function automatic int trained(input int c, input logic taken);
    if (taken) return (c + 1 > 3) ? 3 : c + 1;
    return (c - 1 < 0) ? 0 : c - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 3;
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; br = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_vec(input int k, input logic r, input logic [31:0] lpc,
                         input logic b, input logic p, input logic z,
                         input logic [31:0] pcb, input logic [31:0] pcd,
                         input logic ep, input logic ef, input logic [31:0] er,
                         input logic [31:0] eb, input logic [31:0] em);
    vecs[k] = '{r, lpc, b, p, z, pcb, pcd, ep, ef, er, eb, em};
  endtask

  initial begin
    rst = 1'b0; lookup_pc = '0; br = 1'b0; pred_i = 1'b0; zero = 1'b0;
    pc_b = '0; pc_d = '0;

    //            rst lpc   br p  z  pcb     pcd    pred        flush redir  b  m
    set_vec(0,  0, 32'h10, 1, 1, 0, 32'h40,  32'h14, 1,          1, 32'h14, 1, 1);
    set_vec(1,  0, 32'h20, 1, 1, 0, 32'h40,  32'h14, 1,          1, 32'h14, 2, 2);
    set_vec(2,  0, 32'h10, 0, 1, 1, 32'h123, 32'h456,0,          0, 32'h123,2, 2);
    set_vec(3,  0, 32'h10, 1, 0, 0, 32'h40,  32'h14, 0,          0, 32'h14, 3, 2);
    set_vec(4,  0, 32'h10, 1, 0, 0, 32'h40,  32'h14, 0,          0, 32'h14, 4, 2);
    set_vec(5,  0, 32'h10, 0, 0, 0, 32'h0,   32'h0,  0,          0, 32'h0,  4, 2);
    set_vec(6,  0, 32'h20, 1, 1, 1, 32'h80,  32'h24, 1,          0, 32'h80, 5, 2);
    set_vec(7,  0, 32'h50, 1, 0, 1, 32'h200, 32'h14, 0,          1, 32'h200,6, 3);
    set_vec(8,  0, 32'h50, 1, 0, 1, 32'h200, 32'h14, BYP,        1, 32'h200,7, 4);
    set_vec(9,  0, 32'h50, 1, 1, 0, 32'h200, 32'h14, !BYP,       1, 32'h14, 8, 5);
    set_vec(10, 0, 32'h10, 0, 0, 0, 32'h0,   32'h0,  0,          0, 32'h0,  8, 5);
    set_vec(11, 1, 32'h10, 1, 1, 0, 32'h40,  32'h14, 0,          0, 32'h14, 0, 0);
    set_vec(12, 0, 32'h10, 0, 0, 0, 32'h0,   32'h0,  1,          0, 32'h0,  0, 0);
    set_vec(13, 0, 32'h3C, 1, 1, 0, 32'h8,   32'h0,  1,          1, 32'h0,  1, 1);
    set_vec(14, 0, 32'h3C, 0, 0, 0, 32'h0,   32'h0,  1,          0, 32'h0,  1, 1);
    set_vec(15, 0, 32'h7C, 1, 1, 0, 32'h8,   32'h0,  !BYP,       1, 32'h0,  2, 2);
    set_vec(16, 0, 32'h3C, 0, 0, 0, 32'h0,   32'h0,  0,          0, 32'h0,  2, 2);

    // Reset sweep.
    do_reset();
    for (int pc = 0; pc <= 'h3C; pc += 4) begin
      lookup_pc = 32'(pc);
      #1;
      chk($sformatf("reset_pred_%0h", pc), {31'b0, pred_o}, 32'd1);
    end
    chk("reset_flush", {31'b0, flush}, 32'd0);
    chk("reset_bcnt", bcnt, 32'd0);
    chk("reset_mcnt", mcnt, 32'd0);

    // Directed table.
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      rst = vecs[k].rst; lookup_pc = vecs[k].lpc; br = vecs[k].br;
      pred_i = vecs[k].pred; zero = vecs[k].zero;
      pc_b = vecs[k].pcb; pc_d = vecs[k].pcd;
      #1;
      chk($sformatf("v%0d_pred", k),  {31'b0, pred_o}, {31'b0, vecs[k].e_pred});
      chk($sformatf("v%0d_flush", k), {31'b0, flush},  {31'b0, vecs[k].e_flush});
      chk($sformatf("v%0d_redir", k), redir, vecs[k].e_redir);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_bcnt", k), bcnt, vecs[k].e_bcnt);
      chk($sformatf("v%0d_mcnt", k), mcnt, vecs[k].e_mcnt);
    end

    // Randomised run against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int          li, ui, nc;
      logic        ep, ef;
      logic [31:0] er;
      @(negedge clk);
      rst       = ($urandom_range(0, 49) == 0);
      br        = $urandom_range(0, 1);
      pred_i    = $urandom_range(0, 1);
      zero      = $urandom_range(0, 1);
      lookup_pc = $urandom_range(0, 255) << 2 | ($urandom_range(0, 3));
      pc_d      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8))
                                               : $urandom;
      pc_b      = $urandom;
      li = idx_of(lookup_pc);
      ui = idx_of(pc_d - 32'd4);
      nc = trained(m_ctr[ui], zero);
      ep = (m_ctr[li] >= 2);
      if (BYP && br && !rst && li == ui) ep = (nc >= 2);
      ef = br && !rst && (pred_i != zero);
      er = zero ? pc_b : pc_d;
      #1;
      chk("rnd_pred",  {31'b0, pred_o}, {31'b0, ep});
      chk("rnd_flush", {31'b0, flush},  {31'b0, ef});
      chk("rnd_redir", redir, er);
      @(posedge clk);
      if (rst) model_reset();
      else if (br) begin
        m_ctr[ui] = nc;
        m_bcnt = m_bcnt + 1;
        if (ef) m_mcnt = m_mcnt + 1;
      end
      #1;
      chk("rnd_bcnt", bcnt, m_bcnt);
      chk("rnd_mcnt", mcnt, m_mcnt);
    end

    // Mispredict counter wrap, then reset with a branch in EX.
    @(negedge clk);
    rst = 1'b0; br = 1'b0;
    force dut.mispred_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.mispred_cnt_q;
    #1;
    chk("wrap_preload", mcnt, 32'hFFFF_FFFF);
    @(negedge clk);
    br = 1'b1; pred_i = 1'b1; zero = 1'b0; pc_d = 32'h14; pc_b = 32'h40;
    #1;
    chk("wrap_flush", {31'b0, flush}, 32'd1);
    @(posedge clk);
    #1;
    chk("wrap_mcnt", mcnt, 32'd0);
    chk("wrap_bcnt", bcnt, m_bcnt + 32'd1);
    @(negedge clk);
    rst = 1'b1; br = 1'b1; pred_i = 1'b1; zero = 1'b0;
    #1;
    chk("rst_br_flush", {31'b0, flush}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; br = 1'b0; lookup_pc = 32'h10;
    #1;
    chk("rst_br_bcnt", bcnt, 32'd0);
    chk("rst_br_mcnt", mcnt, 32'd0);
    chk("rst_br_pred", {31'b0, pred_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Branch history table plus misprediction resolver for the 5-stage RISC-V pipeline. In ID it supplies `predTaken_o` for the instruction being decoded, which is latched into the ID/EX register. In EX it consumes the branch fields from the ID/EX register (`Branch`, `predTaken`, `pc_branch`, `pc_default`) and the ALU zero flag. From these it trains a table of 2-bit saturating counters, raises the flush to IF/ID and ID/EX on a misprediction, and supplies the corrected fetch PC.

## Interface
Parameters:
- `ENTRIES`, 16, number of 2-bit counters; power of two, 2..256.
- `IDX_LSB`, 2, lowest PC bit used for the table index.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `lookup_pc_i`  in  32  PC of the instruction currently in ID.
- `predTaken_o`  out  1  prediction for `lookup_pc_i`; goes to the ID/EX `predTaken_i`.
- `Branch_i`  in  1  ID/EX `Branch_o`; a conditional branch is in EX.
- `predTaken_i`  in  1  ID/EX `predTaken_o`.
- `zero_i`  in  1  ALU zero flag; actual branch outcome (1 = taken).
- `pc_branch_i`  in  32  ID/EX `pc_branch_o`; branch target.
- `pc_default_i`  in  32  ID/EX `pc_default_o`; branch PC + 4.
- `flush_o`  out  1  flush IF/ID and ID/EX on the next edge.
- `redirect_pc_o`  out  32  corrected next PC; valid when `flush_o` = 1.
- `branch_cnt_o`  out  32  number of resolved branches.
- `mispred_cnt_o`  out  32  number of mispredicted branches.

## Operation
- Table: `ENTRIES` counters with encoding 00 = SNT, 01 = WNT, 10 = WT, 11 = ST. Prediction = counter MSB.
- Lookup index: `lookup_pc_i[IDX_LSB +: log2(ENTRIES)]`. `predTaken_o` is a combinational read of that entry.
- Update index: derived from `pc_default_i - 32'd4` using the same bit field. The subtraction is 32-bit and wraps.
- Update happens only when `Branch_i` = 1:
  - taken (`zero_i` = 1): counter increments, saturating at 11.
  - not taken: counter decrements, saturating at 00.
  - When `Branch_i` = 0, including ID/EX bubbles (all-zero fields), nothing changes.
- Mispredict = `Branch_i & (predTaken_i != zero_i)`.
- `flush_o` = mispredict. It is combinational, so IF/ID and ID/EX discard wrong-path instructions at the same edge the branch leaves EX.
- `redirect_pc_o` = `zero_i ? pc_branch_i : pc_default_i`. It is driven regardless of `flush_o`.
- Statistics:
  - `branch_cnt_o` increments on every cycle with `Branch_i` = 1.
  - `mispred_cnt_o` increments on every mispredict.
  - Both are 32-bit and wrap from FFFF_FFFF to 0.
- While `rst_i` = 1, `flush_o` is forced to 0 and no counter or statistic updates occur.

## Timing
- Reset: all table entries become 11 (ST). Therefore `predTaken_o` = 1 for every PC in the cycle after reset. `branch_cnt_o` = 0, `mispred_cnt_o` = 0, `flush_o` = 0.
- Lookup latency: 0 cycles, combinational from `lookup_pc_i`.
- Update latency: the table write takes effect at the rising edge closing the EX cycle. It is visible to lookups from the following cycle.
- Same-cycle lookup and update of the same index: `predTaken_o` returns the pre-update counter, unless `BPRED_BYPASS_EN` is defined.
- Aliasing: different PCs with the same index share one counter. This is intended and needs no detection.
- Back-to-back branches in consecutive EX cycles: each updates independently. Two updates to the same index accumulate (for example, 00 followed by two taken updates gives 10).
- Reset asserted mid-stream: table and statistics reinitialise at that edge. A branch in EX during the reset cycle is neither counted nor trained.

## Configuration
- Macro: `BPRED_BYPASS_EN`.
- Defined: when the lookup index equals the update index and `Branch_i` = 1 in the same cycle, `predTaken_o` = MSB of the new (post-update) counter value. This bypass is combinational.
- Undefined: `predTaken_o` always reflects the stored table content.

## Test plan
- Reset check: assert `rst_i` for 1 cycle, then release and sweep `lookup_pc_i` over 0x00..0x3C. Expect `predTaken_o` = 1 everywhere and both counts = 0.
- Single misprediction: `Branch_i`=1, `predTaken_i`=1, `zero_i`=0, `pc_default_i`=0x14, `pc_branch_i`=0x40.
  - Same cycle: `flush_o`=1, `redirect_pc_o`=0x14.
  - Next cycle: lookup 0x10 still returns 1 (counter 10); `mispred_cnt_o`=1, `branch_cnt_o`=1.
- Training to not-taken: three not-taken resolves at PC 0x10. Expect the counter to go 11→10→01→00, with lookup 0x10 returning 1, 0, 0 after each step. A fourth not-taken resolve leaves it at 00 (saturation).
- Correct prediction and bubble:
  - Taken branch with `predTaken_i`=1, `zero_i`=1: `flush_o`=0, `branch_cnt_o` increments.
  - `Branch_i`=0 with arbitrary other inputs: no flush, no count change, no table change.
- Aliasing and same-index collision (`ENTRIES`=16): a resolve at PC 0x10 and a lookup at 0x50 in the same cycle, both index 4.
  - Without the macro, the lookup shows the old value.
  - With `BPRED_BYPASS_EN`, it shows the new value (starting from 10 with not-taken, the lookup returns 0 in that cycle).
- Wrap and reset mid-run: preload `mispred_cnt_o` to FFFF_FFFF via 2^32−1 forced mispredicts (or a backdoor force), then mispredict once and expect 0. Assert `rst_i` while `Branch_i`=1: no update, and counts = 0 on the next cycle.
